wash_stage_monitor: RTL and testbench

WASH_STAGE_MONITOR -- requirements
Module: wash_stage_monitor

---
 rtl/wm_pkg.sv | 61 ++++++
 rtl/wm_dwell_counter.sv | 41 ++++
 rtl/wash_stage_monitor.sv | 150 +++++++++++++++
 tb/tb_wash_stage_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the wash stage monitor.
//   stage_e     : controller stage codes (IDLE..STOP, 6/7 unused)
//   err_e       : latched error cause reported on err_code
//   mon_state_e : monitor FSM states
//   act_t       : actuator drive bundle
//   successor() : next legal stage in the wash sequence
//   actuators_for() : actuator pattern for a given stage
package wm_pkg;

  typedef enum logic [2:0] {
    STG_IDLE  = 3'd0,
    STG_FILL  = 3'd1,
    STG_WASH  = 3'd2,
    STG_RINSE = 3'd3,
    STG_SPIN  = 3'd4,
    STG_STOP  = 3'd5
  } stage_e;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_ILLEGAL_STEP  = 3'd1,
    ERR_BAD_CODE      = 3'd2,
    ERR_TIMEOUT       = 3'd3,
    ERR_DONE_MISMATCH = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_TRACK = 2'd1,
    MON_ERR   = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic water_valve;
    logic motor_on;
    logic motor_fast;
    logic drain_pump;
    logic door_lock;
  } act_t;

  // STOP wraps back to IDLE; codes above STOP never reach here as a
  // recorded stage, but map them to IDLE for completeness.
  function automatic logic [2:0] successor(input logic [2:0] s);
    logic [2:0] n;
    if (s >= STG_STOP) n = STG_IDLE;
    else               n = s + 3'd1;
    return n;
  endfunction

  function automatic act_t actuators_for(input logic [2:0] s);
    act_t a;
    a = '0;
    a.water_valve = (s == STG_FILL);
    a.motor_on    = (s == STG_WASH) || (s == STG_RINSE) || (s == STG_SPIN);
    a.motor_fast  = (s == STG_SPIN);
    a.drain_pump  = (s == STG_RINSE) || (s == STG_SPIN);
    a.door_lock   = (s >= STG_FILL) && (s <= STG_STOP);
    return a;
  endfunction

endpackage

// File: rtl/wm_dwell_counter.sv
// Dwell counter for the wash stage monitor.
//   clk, reset : clock and synchronous active-high reset
//   clr        : restart the count at zero (has priority over inc)
//   inc        : count one run-enabled cycle; holds when low
//   tc         : pulses on the cycle the count steps onto MAX_DWELL
// The count saturates at its all-ones value.
module wm_dwell_counter #(
  parameter int CNT_W     = 8,
  parameter int MAX_DWELL = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   LIMIT   = (CNT_W+1)'(MAX_DWELL);
  localparam logic [CNT_W:0]   ONE     = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             can_step;
  logic [CNT_W:0]   cnt_plus;

  assign can_step = inc && !clr && (cnt_q != CNT_MAX);
  // One bit wider so a MAX_DWELL at the saturation value still compares.
  assign cnt_plus = {1'b0, cnt_q} + ONE;
  assign tc       = can_step && (cnt_plus == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (can_step) begin
      cnt_q <= cnt_plus[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/wash_stage_monitor.sv
// Wash stage monitor: watches the controller's stage/done/start signals,
// drives the actuators from the observed stage, and latches the first
// sequencing error.
//   clk, reset      : clock, synchronous active-high reset
//   start           : run enable (low = paused; checking continues)
//   stage[2:0]      : controller stage code
//   done            : controller done flag, expected high only in STOP
//   clear_err       : pulse that releases a latched error
//   water_valve, motor_on, motor_fast, drain_pump, door_lock : actuators
//   seq_err         : sticky error flag
//   err_code[2:0]   : cause of the first latched error
//   cycles_done     : saturating count of completed wash cycles
//
// state     | meaning
// MON_IDLE  | no wash in progress, last stage seen was IDLE
// MON_TRACK | wash in progress, checking each step against prev_stage
// MON_ERR   | error latched, actuators off, waiting for clear_err
module wash_stage_monitor
  import wm_pkg::*;
#(
  parameter int MAX_DWELL = 15,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       stage,
  input  logic             done,
  input  logic             clear_err,
  output logic             water_valve,
  output logic             motor_on,
  output logic             motor_fast,
  output logic             drain_pump,
  output logic             door_lock,
  output logic             seq_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] cycles_done
);

  mon_state_e       state_q, state_d;
  logic [2:0]       prev_q;
  act_t             act_q, act_d;
  logic             seq_err_q;
  err_e             err_q, err_now;
  logic [CNT_W-1:0] cyc_q;

  logic tracking, stage_chg, in_run_stage;
  logic bad_code, done_mis, ill_step, timeout, err_hit, wrap_ok;
  logic dwell_clr, dwell_inc, dwell_tc;

  // IDLE and TRACK both check; only ERR suspends checking.
  assign tracking     = (state_q != MON_ERR);
  assign stage_chg    = (stage != prev_q);
  assign in_run_stage = (stage >= STG_FILL) && (stage <= STG_SPIN);

  assign bad_code = (stage > STG_STOP);
  assign done_mis = (done != (stage == STG_STOP));
  assign ill_step = stage_chg && (stage != successor(prev_q));
  assign timeout  = dwell_tc && in_run_stage;
  assign wrap_ok  = (prev_q == STG_STOP) && (stage == STG_IDLE);

  always_comb begin
    err_now = ERR_NONE;
    if (bad_code)      err_now = ERR_BAD_CODE;
    else if (done_mis) err_now = ERR_DONE_MISMATCH;
    else if (ill_step) err_now = ERR_ILLEGAL_STEP;
    else if (timeout)  err_now = ERR_TIMEOUT;
  end

  assign err_hit = tracking && (err_now != ERR_NONE);

  // Entry cycle of a stage clears the count; each later run-enabled cycle
  // in that stage adds one. In ERR the count holds until clear_err.
  assign dwell_clr = tracking ? stage_chg : clear_err;
  assign dwell_inc = tracking && start && !stage_chg;

  wm_dwell_counter #(
    .CNT_W     (CNT_W),
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (dwell_clr),
    .inc   (dwell_inc),
    .tc    (dwell_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= MON_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MON_IDLE: begin
        if (err_hit)                 state_d = MON_ERR;
        else if (stage != STG_IDLE)  state_d = MON_TRACK;
      end
      MON_TRACK: begin
        if (err_hit)                 state_d = MON_ERR;
        else if (stage == STG_IDLE)  state_d = MON_IDLE;
      end
      MON_ERR: begin
        if (clear_err)               state_d = MON_IDLE;
      end
      default:                       state_d = MON_IDLE;
    endcase
  end

  always_comb begin
    act_d = '0;
    if (tracking && !err_hit) act_d = actuators_for(stage);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= STG_IDLE;
      act_q     <= '0;
      seq_err_q <= 1'b0;
      err_q     <= ERR_NONE;
      cyc_q     <= '0;
    end else begin
      act_q <= act_d;
      if (tracking) begin
        prev_q <= stage;
        if (err_hit) begin
          seq_err_q <= 1'b1;
          err_q     <= err_now;
        end else if (wrap_ok && (cyc_q != '1)) begin
          cyc_q <= cyc_q + 1'b1;
        end
      end else if (clear_err) begin
        prev_q    <= STG_IDLE;
        seq_err_q <= 1'b0;
        err_q     <= ERR_NONE;
      end
    end
  end

  assign water_valve = act_q.water_valve;
  assign motor_on    = act_q.motor_on;
  assign motor_fast  = act_q.motor_fast;
  assign drain_pump  = act_q.drain_pump;
  assign door_lock   = act_q.door_lock;
  assign seq_err     = seq_err_q;
  assign err_code    = err_q;
  assign cycles_done = cyc_q;

endmodule

// File: tb/tb_wash_stage_monitor.sv
// Self-checking bench for wash_stage_monitor: a vector table, hand-written
// multi-cycle corner cases, then random stimulus against a behavioural model.
module tb_wash_stage_monitor;

  localparam int MAX_DWELL = 15;
  localparam int CNT_W     = 8;
  localparam int CYC_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, start, done, clear_err;
  logic [2:0]       stage;
  logic             water_valve, motor_on, motor_fast, drain_pump, door_lock;
  logic             seq_err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] cycles_done;

  wash_stage_monitor #(.MAX_DWELL(MAX_DWELL), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stage       (stage),
    .done        (done),
    .clear_err   (clear_err),
    .water_valve (water_valve),
    .motor_on    (motor_on),
    .motor_fast  (motor_fast),
    .drain_pump  (drain_pump),
    .door_lock   (door_lock),
    .seq_err     (seq_err),
    .err_code    (err_code),
    .cycles_done (cycles_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: last accepted stage, run-enabled cycles spent in it,
  // and the expected observable outputs.
  int         m_prev, m_run, m_code, m_cyc;
  bit         m_err;
  logic [4:0] m_act;
  logic [4:0] act_tbl [8];

  typedef struct {
    logic       r, s;
    logic [2:0] g;
    logic       d, c;
    logic [4:0] act;
    logic       err;
    logic [2:0] code;
    logic [7:0] cyc;
  } vec_t;
  vec_t vt[$];

  function automatic logic [16:0] dut_vec();
    return {water_valve, motor_on, motor_fast, drain_pump, door_lock,
            seq_err, err_code, cycles_done};
  endfunction

  function automatic logic [16:0] model_vec();
    return {m_act, m_err, 3'(m_code), 8'(m_cyc)};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got act=%b err=%b code=%0d cyc=%0d, want act=%b err=%b code=%0d cyc=%0d",
               name, got[16:12], got[11], got[10:8], got[7:0],
               want[16:12], want[11], want[10:8], want[7:0]);
    end
  endtask

  function automatic void model_step(input logic r, input logic s, input logic [2:0] g,
                                     input logic d, input logic c);
    int  code;
    int  nxt;
    bit  changed;
    if (r) begin
      m_prev = 0; m_run = 0; m_code = 0; m_err = 0; m_cyc = 0; m_act = '0;
      return;
    end
    if (m_err) begin
      m_act = '0;
      if (c) begin
        m_err = 0; m_code = 0; m_prev = 0; m_run = 0;
      end
      return;
    end
    changed = (int'(g) != m_prev);
    nxt     = (m_prev == 5) ? 0 : m_prev + 1;
    code    = 0;
    if (g >= 6)                                  code = 2;
    else if (d != (g == 3'd5))                   code = 4;
    else if (changed && int'(g) != nxt)          code = 1;
    else if (!changed && s && g >= 1 && g <= 4 && m_run + 1 == MAX_DWELL) code = 3;
    if (changed)                m_run = 0;
    else if (s && m_run < CYC_MAX) m_run++;
    if (code != 0) begin
      m_err = 1; m_code = code; m_act = '0;
    end else begin
      m_act = act_tbl[g];
      if (m_prev == 5 && g == 0 && m_cyc < CYC_MAX) m_cyc++;
    end
    m_prev = int'(g);
  endfunction

  task automatic tick(input logic r, input logic s, input logic [2:0] g,
                      input logic d, input logic c);
    reset = r; start = s; stage = g; done = d; clear_err = c;
    @(posedge clk);
    #1;
    model_step(r, s, g, d, c);
  endtask

  task automatic add(input logic r, input logic s, input logic [2:0] g, input logic d,
                     input logic c, input logic [4:0] act, input logic err,
                     input logic [2:0] code, input logic [7:0] cyc);
    vec_t v;
    v.r = r; v.s = s; v.g = g; v.d = d; v.c = c;
    v.act = act; v.err = err; v.code = code; v.cyc = cyc;
    vt.push_back(v);
  endtask

  // {water, motor_on, motor_fast, drain, door}, err, code, cycles (after edge)
  localparam logic [4:0] A0 = 5'b00000, A1 = 5'b10001, A2 = 5'b01001,
                         A3 = 5'b01011, A4 = 5'b01111, A5 = 5'b00001;

  initial begin
    logic [2:0] cur;
    act_tbl[0] = A0; act_tbl[1] = A1; act_tbl[2] = A2; act_tbl[3] = A3;
    act_tbl[4] = A4; act_tbl[5] = A5; act_tbl[6] = A0; act_tbl[7] = A0;
    m_prev = 0; m_run = 0; m_code = 0; m_err = 0; m_cyc = 0; m_act = '0;
    reset = 1'b1; start = 1'b0; stage = 3'd0; done = 1'b0; clear_err = 1'b0;

    // nominal cycle
    add(1,1,0,0,0, A0,0,0,0);
    add(0,1,0,0,0, A0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,1,0,0, A1,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,2,0,0, A2,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,3,0,0, A3,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,4,0,0, A4,0,0,0);
    add(0,1,5,1,0, A5,0,0,0);
    add(0,1,0,0,0, A0,0,0,1);
    // reset mid-WASH
    add(0,1,1,0,0, A1,0,0,1);
    add(0,1,2,0,0, A2,0,0,1);
    add(1,1,2,0,0, A0,0,0,0);
    // illegal step, later error does not overwrite, reset while in error
    add(0,1,1,0,0, A1,0,0,0);
    add(0,1,3,0,0, A0,1,1,0);
    add(0,1,7,1,0, A0,1,1,0);
    add(1,1,0,0,0, A0,0,0,0);
    // bad code + done mismatch + illegal together, then clear
    add(0,1,7,1,0, A0,1,2,0);
    add(0,1,0,0,1, A0,0,0,0);
    add(0,1,0,0,0, A0,0,0,0);
    add(0,1,1,0,0, A1,0,0,0);
    // done mismatch on a held stage, clear, clear ignored outside error
    add(0,1,1,1,0, A0,1,4,0);
    add(0,1,1,0,1, A0,0,0,0);
    add(0,1,1,0,1, A1,0,0,0);
    // done mismatch outranks illegal step
    add(0,1,3,1,0, A0,1,4,0);
    add(0,1,0,0,1, A0,0,0,0);
    // checking continues while paused
    add(0,1,1,0,0, A1,0,0,0);
    add(0,0,2,0,0, A2,0,0,0);
    add(0,0,4,0,0, A0,1,1,0);
    add(0,1,0,0,1, A0,0,0,0);

    foreach (vt[i]) begin
      tick(vt[i].r, vt[i].s, vt[i].g, vt[i].d, vt[i].c);
      check($sformatf("vec%0d", i), dut_vec(), {vt[i].act, vt[i].err, vt[i].code, vt[i].cyc});
    end

    // timeout boundary: 14 run-enabled holds are fine, the 15th trips
    tick(1,1,0,0,0);
    tick(0,1,1,0,0);
    tick(0,1,2,0,0);
    repeat (14) tick(0,1,2,0,0);
    check("timeout_14", dut_vec(), {A2, 1'b0, 3'd0, 8'd0});
    tick(0,1,2,0,0);
    check("timeout_15", dut_vec(), {A0, 1'b1, 3'd3, 8'd0});
    tick(0,1,0,0,1);
    check("timeout_clear", dut_vec(), {A0, 1'b0, 3'd0, 8'd0});

    // pause holds the dwell count
    tick(0,1,1,0,0);
    tick(0,1,2,0,0);
    repeat (20) tick(0,0,2,0,0);
    check("pause_20", dut_vec(), {A2, 1'b0, 3'd0, 8'd0});
    repeat (14) tick(0,1,2,0,0);
    check("pause_run_14", dut_vec(), {A2, 1'b0, 3'd0, 8'd0});
    tick(0,1,2,0,0);
    check("pause_run_15", dut_vec(), {A0, 1'b1, 3'd3, 8'd0});

    // dwell restarts on a stage change; no timeout in STOP or IDLE
    tick(1,1,0,0,0);
    repeat (40) tick(0,1,0,0,0);
    repeat (12) tick(0,1,1,0,0);
    tick(0,1,2,0,0);
    repeat (14) tick(0,1,2,0,0);
    check("dwell_restart", dut_vec(), {A2, 1'b0, 3'd0, 8'd0});
    tick(0,1,3,0,0);
    tick(0,1,4,0,0);
    repeat (30) tick(0,1,5,1,0);
    check("stop_no_timeout", dut_vec(), {A5, 1'b0, 3'd0, 8'd0});
    tick(0,1,0,0,0);
    check("stop_wrap", dut_vec(), {A0, 1'b0, 3'd0, 8'd1});

    // cycles_done saturation
    tick(1,1,0,0,0);
    for (int i = 0; i < 258; i++) begin
      tick(0,1,1,0,0); tick(0,1,2,0,0); tick(0,1,3,0,0);
      tick(0,1,4,0,0); tick(0,1,5,1,0); tick(0,1,0,0,0);
      if (i == 253) check("cyc_254", dut_vec(), {A0, 1'b0, 3'd0, 8'd254});
    end
    check("cyc_saturate", dut_vec(), {A0, 1'b0, 3'd0, 8'(CYC_MAX)});

    // random stimulus against the model
    tick(1,1,0,0,0);
    check("rand_reset", dut_vec(), model_vec());
    cur = 3'd0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic s, d, c, rs;
      logic [2:0] g;
      r = $urandom_range(0, 99);
      if (r < 3)       g = 3'($urandom_range(0, 7));
      else if (r < 30) g = (cur >= 3'd5) ? 3'd0 : cur + 3'd1;
      else             g = cur;
      d  = (g == 3'd5);
      if ($urandom_range(0, 99) < 3) d = ~d;
      s  = ($urandom_range(0, 9) < 8);
      c  = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 499) == 0);
      if (g > 3'd5) cur = 3'd0; else cur = g;
      tick(rs, s, g, d, c);
      check($sformatf("rand%0d", n), dut_vec(), model_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
